// File: rtl/mm_resp_pkg.sv
// Shared types and helpers for the main-memory miss responder.
//   state_e         : responder FSM states (idle / counting down / responding)
//   LfsrTaps        : tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   LfsrSeedDefault : default nonzero LFSR seed
//   lfsr_step()     : one LFSR advance (shift left, XOR of taps into bit 0)
//   next_delay()    : delay selection, fixed config value or masked LFSR
package mm_resp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Bit k-1 set for tap k.
    localparam logic [15:0] LfsrTaps        = 16'hB400;
    localparam logic [15:0] LfsrSeedDefault = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] lfsr);
        return {lfsr[14:0], ^(lfsr & LfsrTaps)};
    endfunction

    // Returns a 32-bit delay; callers narrow it to their counter width, which is
    // checked at elaboration to hold the largest random delay.
    function automatic logic [31:0] next_delay(
        input logic        use_fixed,
        input logic [31:0] fixed_dly,
        input logic [15:0] lfsr,
        input logic [31:0] min_dly,
        input logic [15:0] dly_mask
    );
        if (use_fixed) begin
            return fixed_dly;
        end
        return min_dly + {16'h0000, lfsr & dly_mask};
    endfunction

endpackage

// File: rtl/mm_miss_responder_if.sv
// Bus between a cache-side requester and the miss responder.
//   c_miss/c_a          : miss request pulse and address (requester -> responder)
//   cfg_fixed/cfg_dly   : delay mode and fixed delay value (requester -> responder)
//   mm_rd/m_a           : read-done pulse and returned address (responder -> requester)
//   pending/busy        : queue occupancy and FSM activity (responder -> requester)
//   overflow            : sticky dropped-miss flag (responder -> requester)
// The parameters must match those of the responder it is attached to.
interface mm_miss_responder_if #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16
) ();

    logic                     c_miss;
    logic [AW-1:0]            c_a;
    logic                     cfg_fixed;
    logic [DW-1:0]            cfg_dly;
    logic                     mm_rd;
    logic [AW-1:0]            m_a;
    logic [$clog2(DEPTH):0]   pending;
    logic                     busy;
    logic                     overflow;

    modport master (
        output c_miss, c_a, cfg_fixed, cfg_dly,
        input  mm_rd, m_a, pending, busy, overflow
    );

    modport slave (
        input  c_miss, c_a, cfg_fixed, cfg_dly,
        output mm_rd, m_a, pending, busy, overflow
    );

endinterface

// File: rtl/miss_fifo.sv
// In-order queue of outstanding miss addresses.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : enqueue push_data this edge
//   push_data : address to enqueue
//   pop       : dequeue the head this edge
//   pop_data  : current head; when the queue is empty this is push_data, so a
//               same-cycle push+pop passes the new entry straight through
//   full      : DEPTH entries stored
//   empty     : no entries stored
//   count     : number of stored entries
// A push while full is ignored unless a pop frees a slot on the same edge.
module miss_fifo #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [AW-1:0]          push_data,
    input  logic                   pop,
    output logic [AW-1:0]          pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic bypass;
    logic wr_en;
    logic rd_en;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;

    // Bypass: the pushed entry is consumed immediately and never stored.
    assign bypass = push && pop && empty;
    assign rd_en  = pop && !empty;
    assign wr_en  = push && !bypass && (!full || rd_en);

    assign pop_data = empty ? push_data : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mm_miss_responder.sv
// Main-memory side of the cache-miss / memory-read protocol.
// Each c_miss is queued in order; the responder takes one request at a time,
// counts down a delay (fixed from cfg_dly, or MIN_DLY plus a masked LFSR value)
// and then pulses mm_rd for one cycle with the request address on m_a.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of mm_miss_responder_if
//          in : c_miss, c_a, cfg_fixed, cfg_dly
//          out: mm_rd, m_a, pending (queued, not started), busy (not idle),
//               overflow (sticky, a miss was dropped)
// With an empty queue a miss sampled at edge E with delay D gives mm_rd high
// from edge E+D+1 to edge E+D+2.
module mm_miss_responder
    import mm_resp_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DW        = 16,
    parameter int unsigned MIN_DLY   = 10,
    parameter logic [15:0] DLY_MASK  = 16'h003F,
    parameter logic [15:0] LFSR_SEED = LfsrSeedDefault
) (
    input logic                clk,
    input logic                rst,
    mm_miss_responder_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Elaboration-time parameter checks.
    if (DW == 0 || DW > 32) begin : g_dw_range
        $error("DW must be in 1..32");
    end
    if ((longint'(MIN_DLY) + longint'(DLY_MASK)) >= (longint'(1) << DW)) begin : g_dly_fit
        $error("MIN_DLY + DLY_MASK does not fit in DW bits");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (LFSR_SEED == 16'h0000) begin : g_seed_nonzero
        $error("LFSR_SEED must be nonzero");
    end

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] m_a_q, m_a_d;
    logic          mm_rd_q, mm_rd_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   lfsr_q, lfsr_d;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW-1:0] fifo_head;
    logic [CW-1:0] fifo_count;
    logic          drop;
    logic [DW-1:0] load_dly;

    miss_fifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.c_miss),
        .push_data (bus.c_a),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // In IDLE a miss arriving into an empty queue is taken on the same edge.
    assign fifo_pop = (state_q == StIdle) && (!fifo_empty || bus.c_miss);
    // Full queue frees a slot only when IDLE pops, so that is the only rescue.
    assign drop     = bus.c_miss && fifo_full && !fifo_pop;

    // Uses the LFSR value before this edge's advance.
    assign load_dly = DW'(next_delay(bus.cfg_fixed, 32'(bus.cfg_dly), lfsr_q,
                                     MIN_DLY, DLY_MASK));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fifo_pop) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        m_a_d      = m_a_q;
        mm_rd_d    = 1'b0;
        overflow_d = overflow_q | drop;
        lfsr_d     = lfsr_step(lfsr_q);
        unique case (state_q)
            StIdle: begin
                if (fifo_pop) begin
                    addr_d = fifo_head;
                    cnt_d  = load_dly;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DW'(1);
                end else begin
                    mm_rd_d = 1'b1;
                    m_a_d   = addr_q;
                end
            end
            StResp:  mm_rd_d = 1'b0;
            default: mm_rd_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            m_a_q      <= '0;
            mm_rd_q    <= 1'b0;
            overflow_q <= 1'b0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            m_a_q      <= m_a_d;
            mm_rd_q    <= mm_rd_d;
            overflow_q <= overflow_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign bus.mm_rd    = mm_rd_q;
    assign bus.m_a      = m_a_q;
    assign bus.pending  = fifo_count;
    assign bus.busy     = (state_q != StIdle);
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_mm_miss_responder.sv
// Bench for mm_miss_responder: a timeline model (queue of addresses, the edge
// at which the current request responds) predicts every output each cycle;
// directed scenarios add hand-computed latency/order/overflow expectations.
module tb_mm_miss_responder;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mm_miss_responder_if #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) bus ();

    mm_miss_responder #(
        .AW        (AW),
        .DEPTH     (DEPTH),
        .DW        (DW),
        .MIN_DLY   (10),
        .DLY_MASK  (16'h003F),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // ---------------- timeline model ----------------
    logic [AW-1:0] m_q[$];
    logic [15:0]   m_lfsr      = 16'hACE1;
    int            m_edge      = 0;
    int            m_pop_edge  = -10;
    int            m_resp_edge = -10;
    logic [AW-1:0] m_cur       = '0;
    logic [AW-1:0] m_ma        = '0;
    logic          m_ovf       = 1'b0;
    int            m_delays[$];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_lfsr      = 16'hACE1;
            m_edge      = 0;
            m_pop_edge  = -10;
            m_resp_edge = -10;
            m_cur       = '0;
            m_ma        = '0;
            m_ovf       = 1'b0;
        end else begin
            bit consumed;
            int d;
            consumed = 1'b0;
            m_edge++;
            // A new request starts once the previous one has had its idle edge.
            if (m_edge >= m_resp_edge + 2 && (m_q.size() > 0 || bus.c_miss)) begin
                if (m_q.size() > 0) m_cur = m_q.pop_front();
                else begin
                    m_cur    = bus.c_a;
                    consumed = 1'b1;
                end
                d = bus.cfg_fixed ? int'(bus.cfg_dly) : 10 + int'(m_lfsr & 16'h003F);
                m_delays.push_back(d);
                m_pop_edge  = m_edge;
                m_resp_edge = m_edge + d + 1;
            end
            if (bus.c_miss && !consumed) begin
                if (m_q.size() == int'(DEPTH)) m_ovf = 1'b1;
                else m_q.push_back(bus.c_a);
            end
            if (m_edge == m_resp_edge) m_ma = m_cur;
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // ---------------- edge counter and miss log ----------------
    int            tb_edge = 0;
    int            miss_edges[$];
    int            rd_edges[$];
    logic [AW-1:0] rd_addrs[$];
    int            max_pending = 0;

    initial forever begin
        @(posedge clk);
        if (rst) tb_edge = 0;
        else begin
            tb_edge++;
            if (bus.c_miss) miss_edges.push_back(tb_edge);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("mm_rd", 64'(bus.mm_rd), 64'(m_edge == m_resp_edge));
        check("m_a", 64'(bus.m_a), 64'(m_ma));
        check("pending", 64'(bus.pending), 64'(m_q.size()));
        check("busy", 64'(bus.busy), 64'(m_edge >= m_pop_edge && m_edge <= m_resp_edge));
        check("overflow", 64'(bus.overflow), 64'(m_ovf));
        if (bus.mm_rd) begin
            rd_edges.push_back(tb_edge);
            rd_addrs.push_back(bus.m_a);
        end
        if (int'(bus.pending) > max_pending) max_pending = int'(bus.pending);
    end

    // ---------------- helpers ----------------
    function automatic int q_int(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    function automatic logic [AW-1:0] q_addr(input logic [AW-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    task automatic clear_logs();
        miss_edges.delete();
        rd_edges.delete();
        rd_addrs.delete();
        m_delays.delete();
        max_pending = 0;
    endtask

    // n consecutive misses with addresses base, base+1, ...
    task automatic miss_burst(input int n, input logic [AW-1:0] base);
        @(posedge clk);
        #2;
        for (int i = 0; i < n; i++) begin
            bus.c_miss = 1'b1;
            bus.c_a    = base + AW'(i);
            @(posedge clk);
            #2;
        end
        bus.c_miss = 1'b0;
        bus.c_a    = '0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!bus.busy && bus.pending == 0 && !bus.mm_rd) done = 1'b1;
        end
        check("idle_reached", 64'(done), 64'(1));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [AW-1:0] base;
        int            d;

        bus.c_miss    = 1'b0;
        bus.c_a       = '0;
        bus.cfg_fixed = 1'b1;
        bus.cfg_dly   = 16'd10;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mm_rd", 64'(bus.mm_rd), 64'(0));
        check("rst_m_a", 64'(bus.m_a), 64'(0));
        check("rst_pending", 64'(bus.pending), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_overflow", 64'(bus.overflow), 64'(0));
        check("model_lfsr_step", 64'(lfsr_next(16'hACE1)), 64'(16'h59C3));
        @(posedge clk);
        #2 rst = 1'b0;

        // Single fixed delay of 10: mm_rd 11 edges after the miss edge.
        repeat (3) @(posedge clk);
        clear_logs();
        miss_burst(1, 32'h0000_1234);
        wait_idle(100);
        check("t1_pulses", 64'(rd_edges.size()), 64'(1));
        check("t1_latency", 64'(q_int(rd_edges, 0) - q_int(miss_edges, 0)), 64'(11));
        check("t1_addr", 64'(q_addr(rd_addrs, 0)), 64'(32'h0000_1234));

        // Zero delay: mm_rd during the cycle right after the miss edge.
        bus.cfg_dly = 16'd0;
        clear_logs();
        miss_burst(1, 32'h0000_0BEE);
        wait_idle(50);
        check("t2_pulses", 64'(rd_edges.size()), 64'(1));
        check("t2_latency", 64'(q_int(rd_edges, 0) - q_int(miss_edges, 0)), 64'(1));
        check("t2_addr", 64'(q_addr(rd_addrs, 0)), 64'(32'h0000_0BEE));

        // Burst of 4 with delay 2: FIFO order, pulse-to-pulse D+3 = 5 edges
        // (RESP edge, idle edge, pop edge, then D+1 to the response).
        bus.cfg_dly = 16'd2;
        base = 32'hA000_0000;
        clear_logs();
        miss_burst(4, base);
        wait_idle(100);
        check("t3_pulses", 64'(rd_edges.size()), 64'(4));
        check("t3_first_latency", 64'(q_int(rd_edges, 0) - q_int(miss_edges, 0)), 64'(3));
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 64'(q_addr(rd_addrs, i)), 64'(base + AW'(i)));
        end
        for (int i = 1; i < 4; i++) begin
            check("t3_spacing", 64'(q_int(rd_edges, i) - q_int(rd_edges, i - 1)), 64'(5));
        end
        check("t3_pending_peak", 64'(max_pending), 64'(3));
        check("t3_overflow", 64'(bus.overflow), 64'(0));

        // Overflow: six misses into one WAIT slot plus a 4-deep queue.
        bus.cfg_dly = 16'd20;
        base = 32'hB000_0000;
        clear_logs();
        miss_burst(6, base);
        wait_idle(400);
        check("t4_pulses", 64'(rd_edges.size()), 64'(5));
        check("t4_overflow", 64'(bus.overflow), 64'(1));
        for (int i = 0; i < 5; i++) begin
            check("t4_order", 64'(q_addr(rd_addrs, i)), 64'(base + AW'(i)));
        end

        // Random mode from a fresh reset: first miss on the first edge out of
        // reset uses the seed, 10 + (16'hACE1 & 16'h3F) = 43.
        @(posedge clk);
        #2;
        rst           = 1'b1;
        bus.cfg_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        clear_logs();
        rst        = 1'b0;
        bus.c_miss = 1'b1;
        bus.c_a    = 32'hC000_0000;
        @(posedge clk);
        #2;
        bus.c_miss = 1'b0;
        bus.c_a    = '0;
        wait_idle(200);
        check("t5_overflow_cleared", 64'(bus.overflow), 64'(0));
        for (int i = 1; i < 10; i++) begin
            miss_burst(1, 32'hC000_0000 + AW'(i));
            wait_idle(200);
        end
        check("t5_pulses", 64'(rd_edges.size()), 64'(10));
        check("t5_first_delay", 64'(q_int(rd_edges, 0) - q_int(miss_edges, 0) - 1), 64'(43));
        for (int i = 0; i < 10; i++) begin
            d = q_int(rd_edges, i) - q_int(miss_edges, i) - 1;
            check("t5_delay_range", 64'(d >= 10 && d <= 73), 64'(1));
            check("t5_delay_model", 64'(d), 64'(q_int(m_delays, i)));
            check("t5_addr", 64'(q_addr(rd_addrs, i)), 64'(32'hC000_0000 + AW'(i)));
        end

        // Reset during WAIT discards the request.
        bus.cfg_fixed = 1'b1;
        bus.cfg_dly   = 16'd30;
        clear_logs();
        miss_burst(1, 32'hD000_0000);
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_no_pulse", 64'(rd_edges.size()), 64'(0));
        check("t6_mm_rd", 64'(bus.mm_rd), 64'(0));
        check("t6_m_a", 64'(bus.m_a), 64'(0));
        check("t6_pending", 64'(bus.pending), 64'(0));
        check("t6_busy", 64'(bus.busy), 64'(0));
        check("t6_overflow", 64'(bus.overflow), 64'(0));
        bus.cfg_dly = 16'd5;
        clear_logs();
        miss_burst(1, 32'hE000_0001);
        wait_idle(50);
        check("t6_post_pulses", 64'(rd_edges.size()), 64'(1));
        check("t6_post_latency", 64'(q_int(rd_edges, 0) - q_int(miss_edges, 0)), 64'(6));
        check("t6_post_addr", 64'(q_addr(rd_addrs, 0)), 64'(32'hE000_0001));

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
